// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the word array and the core: load extraction
// with sign/zero extension, and store merging of sub-word data.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [1:0]       lane,
    input  logic [WIDTH-1:0] rword,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ldata,
    output logic [WIDTH-1:0] mword
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lanes and extend them to a full word.
    always_comb begin
        byte_sel = rword[{lane, 3'b000} +: 8];
        half_sel = rword[{lane[1], 4'b0000} +: 16];
        ldata    = '0;
        case (size)
            SZ_B:    ldata = uns ? {{(WIDTH-8){1'b0}}, byte_sel}
                             : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            SZ_H:    ldata = uns ? {{(WIDTH-16){1'b0}}, half_sel}
                             : {{(WIDTH-16){half_sel[15]}}, half_sel};
            SZ_W:    ldata = rword;
            default: ldata = '0;
        endcase
    end

    // Overlay the low store bytes onto the current word contents.
    always_comb begin
        mword = rword;
        case (size)
            SZ_B:    mword[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    mword[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_W:    mword = wdata;
            default: mword = rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave with configurable wait states over an internal word array.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready high; a request is accepted and checked on this edge
// WAIT  | wait states counting down; array untouched
// RESP  | one-cycle rvalid with rdata (load) or ack/err
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(DEPTH * 4);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]       state;
    logic [3:0]       cnt;

    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [AW+1:0]    r_addr;
    logic [WIDTH-1:0] r_wdata;

    logic             cur_we;
    logic [1:0]       cur_size;
    logic             cur_uns;
    logic [AW+1:0]    cur_addr;
    logic [WIDTH-1:0] cur_wdata;
    logic [AW-1:0]    cur_idx;

    logic             acc_err;
    logic             access_now;
    logic             mem_we;

    logic [WIDTH-1:0] rword;
    logic [WIDTH-1:0] ldata;
    logic [WIDTH-1:0] mword;

    logic [WIDTH-1:0] mem [DEPTH];

    assign ready = (state == S_IDLE);

    // With zero wait states the access happens on the accept edge, so the
    // live request fields are used in IDLE and the latched ones afterwards.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we    = we;
            cur_size  = size;
            cur_uns   = uns;
            cur_addr  = addr[AW+1:0];
            cur_wdata = wdata;
        end else begin
            cur_we    = r_we;
            cur_size  = r_size;
            cur_uns   = r_uns;
            cur_addr  = r_addr;
            cur_wdata = r_wdata;
        end
    end

    assign cur_idx = cur_addr[AW+1:2];
    assign rword   = mem[cur_idx];

    // Illegal requests are detected on acceptance and never touch the array.
    assign acc_err = (size == SZ_X) || is_misaligned(size, addr[1:0]) || (addr >= ADDR_LIMIT);

    // The edge that enters RESP for a legal request performs the access.
    assign access_now = !rst &&
                        (((state == S_IDLE) && req && !acc_err && (WAIT_STATES == 0)) ||
                         ((state == S_WAIT) && (cnt == 4'd0)));
    assign mem_we = access_now && cur_we;

    dmem_lane_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .size  (cur_size),
        .uns   (cur_uns),
        .lane  (cur_addr[1:0]),
        .rword (rword),
        .wdata (cur_wdata),
        .ldata (ldata),
        .mword (mword)
    );

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= mword;
        end
    end

    // Request sequencing, wait-state down-counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_size  <= size;
                        r_uns   <= uns;
                        r_addr  <= addr[AW+1:0];
                        r_wdata <= wdata;
                        if (acc_err) begin
                            state  <= S_RESP;
                            rvalid <= 1'b1;
                            err    <= 1'b1;
                            rdata  <= '0;
                        end else if (WAIT_STATES == 0) begin
                            state  <= S_RESP;
                            rvalid <= 1'b1;
                            err    <= 1'b0;
                            rdata  <= we ? '0 : ldata;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= S_RESP;
                        rvalid <= 1'b1;
                        err    <= 1'b0;
                        rdata  <= r_we ? '0 : ldata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    rdata  <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
